rd_window_sched: RTL and testbench

Read-data window scheduler for the SDRAM datapath of the memory controller. It tracks every read command issued to the SDRAM through a tagged latency pipeline and asserts the read-data capture window exactly CAS-latency cycles later, for one burst. It also tells the command sequencer when a further read or a write may be issued without a DQ collision.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/tag_pipe.sv | 51 +++++
 rtl/rd_window_sched.sv | 142 ++++++++++++++
 tb/tb_rd_window_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller definitions: burst-length codes, CAS latency floor
// and the read-window burst engine state type.
package mem_ctrl_pkg;

    localparam logic [1:0] BL1 = 2'd0;
    localparam logic [1:0] BL2 = 2'd1;
    localparam logic [1:0] BL4 = 2'd2;
    localparam logic [1:0] BL8 = 2'd3;

    localparam logic [2:0] CL_MIN = 3'd2;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } burst_state_t;

    function automatic logic [3:0] bl_beats(input logic [1:0] code);
        logic [3:0] beats;
        case (code)
            BL1:     beats = 4'd1;
            BL2:     beats = 4'd2;
            BL4:     beats = 4'd4;
            default: beats = 4'd8;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/tag_pipe.sv
// Read tag latency pipeline: MAX_LAT stages of {valid, tag} with a
// selectable tap; an entry is retired as it shifts past the tap stage.
module tag_pipe #(
    parameter int TAG_W   = 4,
    parameter int MAX_LAT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [2:0]       sel,
    output logic             tap_valid,
    output logic [TAG_W-1:0] tap_tag,
    output logic             busy
);

    logic             vld [1:MAX_LAT];
    logic [TAG_W-1:0] tg  [1:MAX_LAT];

    // Retiring at the tap keeps consumed reads from reappearing if CL is
    // raised later, and lets "busy" mean "reads still waiting for their tap".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= MAX_LAT; i++) begin
                vld[i] <= 1'b0;
                tg[i]  <= '0;
            end
        end else begin
            vld[1] <= in_valid;
            tg[1]  <= in_tag;
            for (int i = 2; i <= MAX_LAT; i++) begin
                vld[i] <= vld[i-1] && (int'(sel) != i - 1);
                tg[i]  <= tg[i-1];
            end
        end
    end

    always_comb begin
        tap_valid = 1'b0;
        tap_tag   = '0;
        busy      = 1'b0;
        for (int i = 1; i <= MAX_LAT; i++) begin
            busy = busy | vld[i];
            if (i == int'(sel)) begin
                tap_valid = vld[i];
                tap_tag   = tg[i];
            end
        end
    end

endmodule

// File: rtl/rd_window_sched.sv
// Read-data window scheduler: opens the DQ capture window CAS-latency cycles
// after each READ and tells the sequencer when reads/writes may issue.
module rd_window_sched
    import mem_ctrl_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int MAX_LAT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cfg_cl,
    input  logic [1:0]       cfg_bl,
    input  logic             rd_issue,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             err_clr,
    output logic             rd_ok,
    output logic             wr_ok,
    output logic             cap_en,
    output logic [TAG_W-1:0] cap_tag,
    output logic [2:0]       cap_beat,
    output logic             cap_last,
    output logic             err_overlap
);

    burst_state_t     state;
    logic [2:0]       act_cl;
    logic [1:0]       act_bl;
    logic [2:0]       spacing;
    logic             turn;
    logic             pipe_busy;
    logic             tap_valid;
    logic [TAG_W-1:0] tap_tag;
    logic             idle;
    logic             accept;
    logic             reject;
    logic [2:0]       cl_sane;
    logic [1:0]       bl_use;
    logic [2:0]       last_beat;
    logic [2:0]       last_beat_use;

    assign idle    = !pipe_busy && (state == ST_IDLE) && !turn;
    assign rd_ok   = (spacing == 3'd0);
    assign wr_ok   = idle;
    assign accept  = rd_issue && rd_ok;
    assign reject  = rd_issue && !rd_ok;
    assign cl_sane = (cfg_cl < CL_MIN || int'(cfg_cl) > MAX_LAT) ? CL_MIN : cfg_cl;

    // A read issued in an idle cycle is governed by the config latched on
    // that same edge, so its spacing must use the incoming burst length.
    assign bl_use        = idle ? cfg_bl : act_bl;
    assign last_beat     = 3'(bl_beats(act_bl) - 4'd1);
    assign last_beat_use = 3'(bl_beats(bl_use) - 4'd1);

    tag_pipe #(
        .TAG_W   (TAG_W),
        .MAX_LAT (MAX_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_tag    (rd_tag),
        .sel       (act_cl - 3'd1),
        .tap_valid (tap_valid),
        .tap_tag   (tap_tag),
        .busy      (pipe_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cl      <= CL_MIN;
            act_bl      <= BL1;
            spacing     <= 3'd0;
            turn        <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            if (idle) begin
                act_cl <= cl_sane;
                act_bl <= cfg_bl;
            end
            if (accept) begin
                spacing <= last_beat_use;
            end else if (spacing != 3'd0) begin
                spacing <= spacing - 3'd1;
            end
            turn <= cap_en && cap_last;
            if (reject) begin
                err_overlap <= 1'b1;
            end else if (err_clr) begin
                err_overlap <= 1'b0;
            end
        end
    end

    // Burst engine; a tap hit on the final beat chains the next burst gap-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cap_en   <= 1'b0;
            cap_tag  <= '0;
            cap_beat <= 3'd0;
            cap_last <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tap_valid) begin
                        state    <= ST_BURST;
                        cap_en   <= 1'b1;
                        cap_tag  <= tap_tag;
                        cap_beat <= 3'd0;
                        cap_last <= (last_beat == 3'd0);
                    end else begin
                        cap_en   <= 1'b0;
                        cap_last <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (cap_last) begin
                        if (tap_valid) begin
                            cap_en   <= 1'b1;
                            cap_tag  <= tap_tag;
                            cap_beat <= 3'd0;
                            cap_last <= (last_beat == 3'd0);
                        end else begin
                            state    <= ST_IDLE;
                            cap_en   <= 1'b0;
                            cap_beat <= 3'd0;
                            cap_last <= 1'b0;
                        end
                    end else begin
                        cap_beat <= cap_beat + 3'd1;
                        cap_last <= (cap_beat + 3'd1 == last_beat);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cap_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd_window_sched.sv
// Self-checking bench for rd_window_sched: directed scenarios plus random
// traffic compared against a cycle-indexed schedule of expected captures.
module tb_rd_window_sched;

    localparam int TAG_W   = 4;
    localparam int MAX_LAT = 7;
    localparam int N       = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       cfg_cl;
    logic [1:0]       cfg_bl;
    logic             rd_issue;
    logic [TAG_W-1:0] rd_tag;
    logic             err_clr;
    logic             rd_ok;
    logic             wr_ok;
    logic             cap_en;
    logic [TAG_W-1:0] cap_tag;
    logic [2:0]       cap_beat;
    logic             cap_last;
    logic             err_overlap;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Model state: who may issue when, and the expected capture per cycle.
    int   busy_until;
    int   last_acc;
    int   last_bl;
    int   m_cl;
    int   m_bl;
    logic m_err;
    logic             exp_en   [N];
    logic [TAG_W-1:0] exp_tag  [N];
    int               exp_beat [N];
    logic             exp_last [N];

    rd_window_sched #(
        .TAG_W   (TAG_W),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_cl      (cfg_cl),
        .cfg_bl      (cfg_bl),
        .rd_issue    (rd_issue),
        .rd_tag      (rd_tag),
        .err_clr     (err_clr),
        .rd_ok       (rd_ok),
        .wr_ok       (wr_ok),
        .cap_en      (cap_en),
        .cap_tag     (cap_tag),
        .cap_beat    (cap_beat),
        .cap_last    (cap_last),
        .err_overlap (err_overlap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            if (i >= cyc) begin
                exp_en[i]   = 1'b0;
                exp_last[i] = 1'b0;
                exp_tag[i]  = '0;
                exp_beat[i] = 0;
            end
        end
        busy_until = -100;
        last_acc   = -100;
        last_bl    = 1;
        m_cl       = 2;
        m_bl       = 1;
        m_err      = 1'b0;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_cap_en", 32'(cap_en), 32'd0);
        checkOutput("rst_cap_tag", 32'(cap_tag), 32'd0);
        checkOutput("rst_cap_beat", 32'(cap_beat), 32'd0);
        checkOutput("rst_cap_last", 32'(cap_last), 32'd0);
        checkOutput("rst_err", 32'(err_overlap), 32'd0);
        checkOutput("rst_rd_ok", 32'(rd_ok), 32'd1);
        checkOutput("rst_wr_ok", 32'(wr_ok), 32'd1);
    endtask

    // Called just after a rising edge; reset takes effect without a clock.
    task automatic doReset();
        rst      = 1'b1;
        rd_issue = 1'b0;
        err_clr  = 1'b0;
        #1;
        checkResetValues();
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        cyc++;
    endtask

    // One clock cycle: drive inputs, predict, check at the falling edge.
    task automatic applyStimulus(input logic issue, input logic [TAG_W-1:0] tag,
                                 input logic [2:0] cl, input logic [1:0] bl, input logic clr);
        logic e_rdok;
        logic e_wrok;
        logic acc;
        rd_issue = issue;
        rd_tag   = tag;
        cfg_cl   = cl;
        cfg_bl   = bl;
        err_clr  = clr;
        e_wrok = (cyc > busy_until);
        if (e_wrok) begin
            m_cl = (int'(cl) < 2 || int'(cl) > MAX_LAT) ? 2 : int'(cl);
            m_bl = 1 << bl;
        end
        e_rdok = (cyc >= last_acc + last_bl);
        acc    = issue && e_rdok;
        @(negedge clk);
        checkOutput("rd_ok", 32'(rd_ok), 32'(e_rdok));
        checkOutput("wr_ok", 32'(wr_ok), 32'(e_wrok));
        checkOutput("err_overlap", 32'(err_overlap), 32'(m_err));
        checkOutput("cap_en", 32'(cap_en), 32'(exp_en[cyc]));
        if (exp_en[cyc]) begin
            checkOutput("cap_tag", 32'(cap_tag), 32'(exp_tag[cyc]));
            checkOutput("cap_beat", 32'(cap_beat), 32'(exp_beat[cyc]));
            checkOutput("cap_last", 32'(cap_last), 32'(exp_last[cyc]));
        end else begin
            checkOutput("cap_last_idle", 32'(cap_last), 32'd0);
        end
        if (acc) begin
            for (int j = 0; j < m_bl; j++) begin
                exp_en[cyc + m_cl + j]   = 1'b1;
                exp_tag[cyc + m_cl + j]  = tag;
                exp_beat[cyc + m_cl + j] = j;
                exp_last[cyc + m_cl + j] = (j == m_bl - 1);
            end
            busy_until = cyc + m_cl + m_bl;
            last_acc   = cyc;
            last_bl    = m_bl;
        end
        if (issue && !e_rdok) begin
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n, input logic [2:0] cl, input logic [1:0] bl);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, cl, bl, 1'b0);
        end
    endtask

    initial begin
        logic [2:0] r_cl;
        logic [1:0] r_bl;
        cyc = 0;
        rst      = 1'b1;
        cfg_cl   = 3'd2;
        cfg_bl   = 2'd0;
        rd_issue = 1'b0;
        rd_tag   = '0;
        err_clr  = 1'b0;
        modelReset();
        #2;
        checkResetValues();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single read CL=3 BL=4");
        idleCycles(10, 3'd3, 2'd2);
        applyStimulus(1'b1, 4'd5, 3'd3, 2'd2, 1'b0);
        idleCycles(10, 3'd3, 2'd2);

        $display("[TB] back-to-back reads CL=2 BL=2");
        applyStimulus(1'b1, 4'd1, 3'd2, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'd0, 3'd2, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'd2, 3'd2, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'd0, 3'd2, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'd3, 3'd2, 2'd1, 1'b0);
        idleCycles(8, 3'd2, 2'd1);

        $display("[TB] overlapping read and error clear");
        applyStimulus(1'b1, 4'd7, 3'd2, 2'd2, 1'b0);
        applyStimulus(1'b0, 4'd0, 3'd2, 2'd2, 1'b0);
        applyStimulus(1'b1, 4'd8, 3'd2, 2'd2, 1'b0);
        idleCycles(5, 3'd2, 2'd2);
        applyStimulus(1'b0, 4'd0, 3'd2, 2'd2, 1'b1);
        idleCycles(3, 3'd2, 2'd2);

        $display("[TB] max latency and config change while busy");
        applyStimulus(1'b1, 4'd9, 3'd7, 2'd3, 1'b0);
        idleCycles(2, 3'd7, 2'd3);
        idleCycles(16, 3'd2, 2'd3);
        applyStimulus(1'b1, 4'd10, 3'd2, 2'd3, 1'b0);
        idleCycles(12, 3'd2, 2'd3);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 4'd11, 3'd3, 2'd3, 1'b0);
        idleCycles(3, 3'd3, 2'd3);
        doReset();
        idleCycles(14, 3'd3, 2'd3);

        $display("[TB] illegal CL clamps to 2");
        idleCycles(2, 3'd0, 2'd0);
        applyStimulus(1'b1, 4'd12, 3'd0, 2'd0, 1'b0);
        idleCycles(5, 3'd0, 2'd0);

        $display("[TB] random traffic");
        r_cl = 3'd3;
        r_bl = 2'd1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                r_cl = 3'($urandom_range(0, 7));
                r_bl = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 999) < 4) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 99) < 35, TAG_W'($urandom_range(0, 15)),
                              r_cl, r_bl, $urandom_range(0, 99) < 10);
            end
        end
        idleCycles(20, r_cl, r_bl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
